param_unified_cache: RTL and testbench
======================================

Name: param_unified_cache

Overview:
- Parametrised direct-mapped unified cache between the processor port and off-chip memory.
- Successor of the fixed 16-set x 4-word cache: line geometry, address and data width, and write-miss policy are all configurable.
- Tags, data and valid bits are held in synthesizable registers; no behavioural SRAM.
- Write-through. Adds saturating hit and miss counters.

Parameters:
- ADDR_W, 16, processor word-address width.
- DATA_W, 16, word width; also the width of offdata.
- WORDS, 4, words per line; power of 2, >=2; OFF_W = log2(WORDS).
- SETS, 16, number of lines; power of 2; IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.
- WRITE_ALLOC, 0, 0 = write-no-allocate; 1 = write-allocate (refill line, then write).
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- macc  in  1  processor access request; held until complete.
- rd  in  1  1 = read, 0 = write; held with macc.
- addr  in  ADDR_W  word address; offset = [OFF_W-1:0], index = next IDX_W bits, tag = upper bits.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data; valid while complete=1.
- complete  out  1  one-cycle done pulse.
- offaddr  out  ADDR_W  memory address.
- rrqst  out  1  line read request.
- rrdy  in  1  memory accepted the read request.
- rdrdy  in  1  memory word valid on offdata.
- rdacpt  out  1  word consumed.
- wrqst  out  1  write request.
- wacpt  in  1  memory accepted the write.
- offdata  inout  DATA_W  driven with din only in WREQ, otherwise high-Z.
- hitcnt  out  CNT_W  saturating hit count.
- misscnt  out  CNT_W  saturating miss count.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE and all valid bits clear.
  - hitcnt and misscnt go to 0.
  - dout goes to 0; complete, rrqst, rdacpt and wrqst go to 0; offdata goes to high-Z; offaddr goes to 0.
  - An in-flight memory handshake is abandoned; a partial refill never sets valid.
- States: IDLE, LOOKUP, RREQ, RDATA, WREQ, DONE.
- IDLE -> LOOKUP when macc=1. Request fields are registered on entry.
- LOOKUP: hit = valid[idx] && tag match.
  - Read hit: dout = line word[offset]; go to DONE; hitcnt +1.
  - Read miss: go to RREQ; misscnt +1.
  - Write hit: update the cached word with din; go to WREQ; hitcnt +1.
  - Write miss, WRITE_ALLOC=0: go to WREQ with the cache untouched; misscnt +1.
  - Write miss, WRITE_ALLOC=1: go to RREQ; misscnt +1.
- RREQ:
  - rrqst=1; offaddr = addr with offset bits zeroed.
  - Hold until rrdy=1, then go to RDATA with the word counter at 0.
- RDATA:
  - Each cycle with rdrdy=1: store offdata in line word[counter], assert rdacpt combinationally in the same cycle, and increment the counter (wraps at WORDS).
  - When rdrdy=0 the counter holds and rdacpt=0.
  - On the last word: write tag and set valid.
  - Read: dout = refilled word[offset]; go to DONE.
  - Allocating write: merge din into word[offset]; go to WREQ.
- WREQ:
  - wrqst=1; offaddr = addr; offdata = din.
  - Hold until wacpt=1, then go to DONE.
- DONE: complete=1 for exactly one cycle, then IDLE.
- dout holds its value until the next read completes.
- Latency:
  - Read hit: complete is 2 cycles after macc is sampled.
  - Read miss: 2 + rrdy wait + WORDS rdrdy beats.
- The processor must not change macc, rd, addr or din before complete. macc sampled in DONE is ignored; a new access starts from IDLE.
- Counters saturate at 2^CNT_W-1; no wrap.
- rrqst and wrqst are never asserted together. offdata is never driven while rrqst or rdacpt is asserted.
- A write-through of a word already cached updates the cache before memory accepts the write; there is no read-back.

Test Plan:
- Read miss after reset: read 0x0045; memory returns 0x1111, 0x2222, 0x3333, 0x4444 -> offaddr=0x0044, 4 rdacpt pulses, dout=0x2222 with complete, misscnt=1, hitcnt=0.
- Read hit: then read 0x0047 -> no rrqst, complete 2 cycles after macc, dout=0x4444, hitcnt=1.
- Conflict miss: read 0x0085 (index 1, tag 2) -> refill at 0x0084; then read 0x0045 misses again; misscnt=3.
- Write hit: with 0x0044 resident, write 0x0046 din=0xBEEF, wacpt after 3 cycles -> offdata=0xBEEF during wrqst, complete after wacpt; read 0x0046 hits with dout=0xBEEF.
- Write-miss policy: write 0x0200 din=0x1234.
  - WRITE_ALLOC=0: no rrqst; then read 0x0200 misses.
  - WRITE_ALLOC=1: refill at 0x0200, then wrqst; read 0x0200 hits with dout=0x1234.
- Reset mid-refill: assert reset after 2 of 4 rdrdy beats -> rrqst, rdacpt and complete low immediately, counters 0; re-read of the same address misses with a full refill.

Source files
------------

// File: rtl/param_unified_cache_if.sv
// Bundle of processor-side and memory-side handshake signals for param_unified_cache.
//   slave  : the cache itself
//   master : the environment (processor plus off-chip memory controller)
// Processor: macc, rd, addr, din -> cache; dout, complete, hitcnt, misscnt <- cache
// Memory   : offaddr, rrqst, rdacpt, wrqst <- cache; rrdy, rdrdy, wacpt -> cache
// The bidirectional offdata bus is a plain inout on the cache, not part of this bundle.
interface param_unified_cache_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              macc;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              complete;
    logic [ADDR_W-1:0] offaddr;
    logic              rrqst;
    logic              rrdy;
    logic              rdrdy;
    logic              rdacpt;
    logic              wrqst;
    logic              wacpt;
    logic [CNT_W-1:0]  hitcnt;
    logic [CNT_W-1:0]  misscnt;

    modport master (
        output macc, rd, addr, din, rrdy, rdrdy, wacpt,
        input  dout, complete, offaddr, rrqst, rdacpt, wrqst, hitcnt, misscnt
    );

    modport slave (
        input  macc, rd, addr, din, rrdy, rdrdy, wacpt,
        output dout, complete, offaddr, rrqst, rdacpt, wrqst, hitcnt, misscnt
    );
endinterface

// File: rtl/param_unified_cache.sv
// Direct-mapped, write-through unified cache with configurable geometry and
// write-miss policy, plus saturating hit/miss counters.
// Ports:
//   clock_i    : clock, all state updates on the rising edge
//   reset_i    : asynchronous active-high reset
//   bus        : processor and memory handshakes (param_unified_cache_if.slave)
//   offdata_io : memory data bus; driven with the write data only while wrqst is high
//
// state  | meaning
// IDLE   | waiting for macc; request fields captured on exit
// LOOKUP | tag compare, hit/miss accounting, write-hit update
// RREQ   | line read request to memory, waiting for rrdy
// RDATA  | collecting WORDS beats of refill data
// WREQ   | write-through of the request word, waiting for wacpt
// DONE   | one-cycle complete pulse
module param_unified_cache #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WORDS       = 4,
    parameter int SETS        = 16,
    parameter int WRITE_ALLOC = 0,
    parameter int CNT_W       = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    param_unified_cache_if.slave     bus,
    inout  wire  [DATA_W-1:0]        offdata_io
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, RREQ, RDATA, WREQ, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] dout_q;
    logic              complete_q;
    logic              rrqst_q;
    logic              wrqst_q;
    logic [ADDR_W-1:0] offaddr_q;
    logic [OFF_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  hitcnt_q;
    logic [CNT_W-1:0]  misscnt_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][WORDS];

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              beat;
    logic              last_beat;
    logic              line_we;
    logic [OFF_W-1:0]  line_word;
    logic [DATA_W-1:0] line_wdata;

    assign off       = addr_q[OFF_W-1:0];
    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign beat      = (state_q == RDATA) && bus.rdrdy;
    assign last_beat = beat && (cnt_q == LAST_WORD);

    // Line write port: write-hit update in LOOKUP, or one refill beat in RDATA.
    // For an allocating write the request word is merged in place of the memory word.
    always_comb begin
        line_we    = 1'b0;
        line_word  = off;
        line_wdata = din_q;
        if (state_q == LOOKUP && !rd_q && hit) begin
            line_we = 1'b1;
        end else if (beat) begin
            line_we    = 1'b1;
            line_word  = cnt_q;
            line_wdata = (!rd_q && cnt_q == off) ? din_q : offdata_io;
        end
    end

    // Tags and data carry no reset; valid bits alone decide whether they mean anything.
    always_ff @(posedge clock_i) begin
        if (line_we) data_q[idx][line_word] <= line_wdata;
        if (last_beat) tag_q[idx] <= tag;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            din_q      <= '0;
            dout_q     <= '0;
            complete_q <= 1'b0;
            rrqst_q    <= 1'b0;
            wrqst_q    <= 1'b0;
            offaddr_q  <= '0;
            cnt_q      <= '0;
            hitcnt_q   <= '0;
            misscnt_q  <= '0;
            valid_q    <= '0;
        end else begin
            complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.macc) begin
                        addr_q  <= bus.addr;
                        rd_q    <= bus.rd;
                        din_q   <= bus.din;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hitcnt_q != {CNT_W{1'b1}}) hitcnt_q <= hitcnt_q + 1'b1;
                        if (rd_q) begin
                            dout_q     <= data_q[idx][off];
                            complete_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            wrqst_q   <= 1'b1;
                            offaddr_q <= addr_q;
                            state_q   <= WREQ;
                        end
                    end else begin
                        if (misscnt_q != {CNT_W{1'b1}}) misscnt_q <= misscnt_q + 1'b1;
                        if (rd_q || WRITE_ALLOC != 0) begin
                            rrqst_q   <= 1'b1;
                            offaddr_q <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            state_q   <= RREQ;
                        end else begin
                            wrqst_q   <= 1'b1;
                            offaddr_q <= addr_q;
                            state_q   <= WREQ;
                        end
                    end
                end
                RREQ: begin
                    if (bus.rrdy) begin
                        rrqst_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RDATA;
                    end
                end
                RDATA: begin
                    if (bus.rdrdy) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (rd_q && cnt_q == off) dout_q <= offdata_io;
                        if (cnt_q == LAST_WORD) begin
                            valid_q[idx] <= 1'b1;
                            if (rd_q) begin
                                complete_q <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                wrqst_q   <= 1'b1;
                                offaddr_q <= addr_q;
                                state_q   <= WREQ;
                            end
                        end
                    end
                end
                WREQ: begin
                    if (bus.wacpt) begin
                        wrqst_q    <= 1'b0;
                        complete_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.complete = complete_q;
    assign bus.offaddr  = offaddr_q;
    assign bus.rrqst    = rrqst_q;
    assign bus.rdacpt   = beat;
    assign bus.wrqst    = wrqst_q;
    assign bus.hitcnt   = hitcnt_q;
    assign bus.misscnt  = misscnt_q;
    assign offdata_io   = wrqst_q ? din_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_param_unified_cache.sv
module tb_param_unified_cache;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        macc = 1'b0, rd = 1'b0;
    logic [15:0] addr = '0, din = '0;
    logic        rrdy, rdrdy, wacpt, mdrv;
    logic [15:0] mdat;

    initial forever #5 clk = ~clk;

    param_unified_cache_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) if0 ();
    param_unified_cache_if #(.ADDR_W(16), .DATA_W(16), .CNT_W(2))  if1 ();
    wire [15:0] off0, off1;

    assign if0.macc  = macc & ~sel;
    assign if1.macc  = macc & sel;
    assign if0.rd    = rd;
    assign if1.rd    = rd;
    assign if0.addr  = addr;
    assign if1.addr  = addr;
    assign if0.din   = din;
    assign if1.din   = din;
    assign if0.rrdy  = rrdy & ~sel;
    assign if1.rrdy  = rrdy & sel;
    assign if0.rdrdy = rdrdy & ~sel;
    assign if1.rdrdy = rdrdy & sel;
    assign if0.wacpt = wacpt & ~sel;
    assign if1.wacpt = wacpt & sel;
    assign off0 = (mdrv && !sel) ? mdat : 16'hzzzz;
    assign off1 = (mdrv && sel)  ? mdat : 16'hzzzz;

    param_unified_cache #(.WRITE_ALLOC(0), .CNT_W(16)) u_dut0 (
        .clock_i(clk), .reset_i(rst), .bus(if0), .offdata_io(off0));
    param_unified_cache #(.WRITE_ALLOC(1), .CNT_W(2)) u_dut1 (
        .clock_i(clk), .reset_i(rst), .bus(if1), .offdata_io(off1));

    wire [15:0] dout_s     = sel ? if1.dout     : if0.dout;
    wire        complete_s = sel ? if1.complete : if0.complete;
    wire        rrqst_s    = sel ? if1.rrqst    : if0.rrqst;
    wire        wrqst_s    = sel ? if1.wrqst    : if0.wrqst;
    wire        rdacpt_s   = sel ? if1.rdacpt   : if0.rdacpt;
    wire [15:0] offaddr_s  = sel ? if1.offaddr  : if0.offaddr;
    wire [15:0] offdata_s  = sel ? off1         : off0;
    wire [15:0] hit_s      = sel ? {14'd0, if1.hitcnt}  : if0.hitcnt;
    wire [15:0] miss_s     = sel ? {14'd0, if1.misscnt} : if0.misscnt;

    int n_chk = 0, n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    logic [15:0] mem [logic [15:0]];
    function automatic logic [15:0] memrd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'h5A5A;
    endfunction

    typedef struct {
        logic        is_rd;
        logic [15:0] dout;
        string       name;
    } exp_t;
    exp_t sbq[$];

    // memory responder knobs and observations
    int          rr_delay = 0, w_delay = 0, gap_beat = -1, abort_beat = -1;
    logic [15:0] exp_raddr = '0, exp_waddr = '0, exp_wdata = '0;
    int          nref = 0, nacpt = 0;
    bit          abort_hit = 0, wacc_seen = 0;

    // scoreboard monitor
    initial begin
        exp_t e;
        logic prev_c = 1'b0;
        forever begin
            @(negedge clk);
            if (complete_s === 1'b1) begin
                if (prev_c) chk("complete_one_cycle", {31'd0, prev_c}, 32'd0);
                if (sbq.size() == 0) begin
                    chk("spurious_complete", sbq.size(), 1);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_rd) chk(e.name, dout_s, e.dout);
                    else chk({e.name, "_wacpt_before_complete"}, {31'd0, wacc_seen}, 32'd1);
                    wacc_seen = 0;
                end
            end
            prev_c = complete_s;
        end
    end

    // memory responder
    initial begin
        int ms, cnt, beat;
        bit gapped;
        logic [15:0] base;
        ms = 0; cnt = 0; beat = 0; gapped = 0; base = '0;
        rrdy = 0; rdrdy = 0; wacpt = 0; mdrv = 0; mdat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rrdy = 0; rdrdy = 0; wacpt = 0; mdrv = 0; ms = 0;
                continue;
            end
            case (ms)
                0: begin
                    if (rrqst_s === 1'b1) begin
                        nref++;
                        chk("refill_addr", offaddr_s, exp_raddr);
                        chk("no_wrqst_with_rrqst", wrqst_s, 0);
                        cnt = rr_delay;
                        ms = 1;
                    end else if (wrqst_s === 1'b1) begin
                        chk("wr_addr", offaddr_s, exp_waddr);
                        chk("wr_data", offdata_s, exp_wdata);
                        cnt = w_delay;
                        ms = 3;
                    end
                end
                1: begin
                    if (cnt == 0) begin
                        rrdy = 1; base = offaddr_s; beat = 0; gapped = 0; ms = 2;
                    end else cnt--;
                end
                2: begin
                    rrdy = 0;
                    if (beat == WORDS) begin
                        rdrdy = 0; mdrv = 0; ms = 0;
                    end else if (beat == gap_beat && !gapped) begin
                        gapped = 1; rdrdy = 0; mdrv = 0;
                        #1 chk("rdacpt_low_in_gap", rdacpt_s, 0);
                    end else begin
                        rdrdy = 1; mdrv = 1; mdat = memrd(base + 16'(beat));
                        if (beat == abort_beat) abort_hit = 1;
                        beat++;
                        #1 if (rdacpt_s === 1'b1) nacpt++;
                    end
                end
                3: begin
                    if (cnt == 0) begin
                        wacpt = 1; mem[offaddr_s] = offdata_s; wacc_seen = 1; ms = 4;
                    end else cnt--;
                end
                default: begin
                    wacpt = 0; ms = 0;
                end
            endcase
        end
    end

    task automatic access(input logic r, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp, input string name, output int lat);
        exp_t e;
        e.is_rd = r; e.dout = exp; e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        rd = r; addr = a; din = d; macc = 1; lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (complete_s === 1'b1) break;
            if (lat > 200) begin
                chk({name, "_timeout"}, complete_s, 1);
                break;
            end
        end
        macc = 0;
    endtask

    initial begin
        int lat, r0, a0;
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int lat, r0, a0;
        mem[16'h0044] = 16'h1111; mem[16'h0045] = 16'h2222;
        mem[16'h0046] = 16'h3333; mem[16'h0047] = 16'h4444;
        mem[16'h0084] = 16'h5555; mem[16'h0085] = 16'h6666;
        mem[16'h0086] = 16'h7777; mem[16'h0087] = 16'h8888;

        repeat (3) @(negedge clk);
        chk("rst_hitcnt", hit_s, 0);
        chk("rst_misscnt", miss_s, 0);
        chk("rst_dout", dout_s, 0);
        chk("rst_complete", complete_s, 0);
        chk("rst_rrqst", rrqst_s, 0);
        chk("rst_wrqst", wrqst_s, 0);
        chk("rst_offaddr", offaddr_s, 0);
        rst = 0;

        // write-allocate instance, 2-bit counters
        sel = 1;
        exp_raddr = 16'h0200; exp_waddr = 16'h0200; exp_wdata = 16'h1234;
        access(0, 16'h0200, 16'h1234, 16'h0000, "wa1_write_miss", lat);
        chk("wa1_refills", nref, 1);
        chk("wa1_mem_written", mem[16'h0200], 16'h1234);
        chk("wa1_misscnt", miss_s, 1);
        access(1, 16'h0200, 0, 16'h1234, "wa1_read_merged", lat);
        chk("wa1_hit_latency", lat, 2);
        access(1, 16'h0201, 0, 16'h585B, "wa1_read_201", lat);
        access(1, 16'h0202, 0, 16'h5858, "wa1_read_202", lat);
        chk("wa1_hitcnt_3", hit_s, 3);
        access(1, 16'h0203, 0, 16'h5859, "wa1_read_203", lat);
        chk("wa1_hitcnt_saturated", hit_s, 3);
        chk("wa1_no_extra_refill", nref, 1);
        @(negedge clk);
        sel = 0;
        nref = 0; nacpt = 0;

        // read miss after reset with rrdy wait and a rdrdy gap
        exp_raddr = 16'h0044; rr_delay = 2; gap_beat = 2;
        access(1, 16'h0045, 0, 16'h2222, "read_miss_45", lat);
        rr_delay = 0; gap_beat = -1;
        chk("miss1_refills", nref, 1);
        chk("miss1_rdacpt_pulses", nacpt, 4);
        chk("miss1_misscnt", miss_s, 1);
        chk("miss1_hitcnt", hit_s, 0);

        access(1, 16'h0047, 0, 16'h4444, "read_hit_47", lat);
        chk("hit47_latency", lat, 2);
        chk("hit47_no_refill", nref, 1);
        chk("hit47_hitcnt", hit_s, 1);

        // conflict on index 1
        exp_raddr = 16'h0084;
        access(1, 16'h0085, 0, 16'h6666, "read_miss_85", lat);
        exp_raddr = 16'h0044;
        access(1, 16'h0045, 0, 16'h2222, "read_conflict_45", lat);
        chk("conflict_misscnt", miss_s, 3);
        chk("conflict_refills", nref, 3);

        // write hit, write-through
        exp_waddr = 16'h0046; exp_wdata = 16'hBEEF; w_delay = 3;
        access(0, 16'h0046, 16'hBEEF, 0, "write_hit_46", lat);
        w_delay = 0;
        chk("wrhit_hitcnt", hit_s, 2);
        chk("wrhit_mem", mem[16'h0046], 16'hBEEF);
        chk("wrhit_no_refill", nref, 3);
        access(1, 16'h0046, 0, 16'hBEEF, "read_after_write_46", lat);
        chk("rdbeef_latency", lat, 2);
        access(1, 16'h0044, 0, 16'h1111, "read_hit_44", lat);
        chk("rd44_hitcnt", hit_s, 4);

        // write miss, no allocate
        exp_waddr = 16'h0200; exp_wdata = 16'h1234;
        access(0, 16'h0200, 16'h1234, 0, "write_miss_200", lat);
        chk("wrmiss_no_refill", nref, 3);
        chk("wrmiss_misscnt", miss_s, 4);
        exp_raddr = 16'h0200;
        access(1, 16'h0200, 0, 16'h1234, "read_miss_200", lat);
        chk("rd200_refills", nref, 4);
        chk("rd200_misscnt", miss_s, 5);

        // reset in the middle of a refill (index 1 currently holds 0x0044 line)
        exp_raddr = 16'h0084; abort_beat = 2;
        @(negedge clk);
        rd = 1; addr = 16'h0085; macc = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (abort_hit) break;
        end
        chk("abort_reached", {31'd0, abort_hit}, 1);
        rst = 1;
        #1;
        chk("abort_rdacpt", rdacpt_s, 0);
        chk("abort_rrqst", rrqst_s, 0);
        chk("abort_complete", complete_s, 0);
        chk("abort_hitcnt", hit_s, 0);
        chk("abort_misscnt", miss_s, 0);
        macc = 0; abort_beat = -1; abort_hit = 0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        r0 = nref; a0 = nacpt;
        access(1, 16'h0085, 0, 16'h6666, "reread_after_reset", lat);
        chk("reread_refills", nref, r0 + 1);
        chk("reread_rdacpt_pulses", nacpt, a0 + 4);
        chk("reread_misscnt", miss_s, 1);
        chk("reread_hitcnt", hit_s, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
